fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that replaces the single-cycle fetch path.
- Holds the fetch PC and issues reads to an instruction memory that may stall or take several cycles.
- Buffers returned instructions in a small prefetch FIFO and hands them to decode with a valid/ready handshake.
- Supports branch/jump redirect with flush, a halt input and a sticky error flag.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit_fifo.sv | 79 +++++++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// default parameter values and PC-alignment helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no request outstanding
        ST_WAIT = 2'd1,   // one request outstanding, response will be buffered
        ST_DROP = 2'd2    // one request outstanding, response will be discarded
    } fetch_state_e;

    localparam int unsigned DEF_ADDR_W   = 16;
    localparam int unsigned DEF_INSTR_W  = 16;
    localparam int unsigned DEF_DEPTH    = 2;
    localparam int unsigned DEF_PC_INC   = 2;
    localparam int unsigned DEF_RESET_PC = 0;

    // Number of low PC bits that must be zero for an aligned fetch address.
    function automatic int unsigned pc_shift(input int unsigned inc);
        return $clog2(inc);
    endfunction

    localparam int unsigned PC_SHIFT = $clog2(DEF_PC_INC);

endpackage

// File: rtl/fetch_unit_if.sv
// Memory-read and decode-handshake signals of the fetch stage.
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) ();

    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_stall;
    logic               mem_done;
    logic [INSTR_W-1:0] mem_data;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic [ADDR_W-1:0]  instr_pc_inc;

    modport master (
        output mem_rd, mem_addr,
        input  mem_stall, mem_done, mem_data,
        output instr_valid, instr, instr_pc, instr_pc_inc,
        input  instr_ready
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_stall, mem_done, mem_data,
        input  instr_valid, instr, instr_pc, instr_pc_inc,
        output instr_ready
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Small synchronous prefetch FIFO. Flush empties it and wins over push;
// the head entry is read straight from registered storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_ADDR_W + DEF_INSTR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointer and occupancy next-state; flush clears everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_next(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_next(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one memory read
// in flight, buffers responses for decode and handles redirect/halt/error.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter int                PC_INC   = DEF_PC_INC,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_unit_if.master      bus,
    output logic              err
);

    localparam int                CNT_W      = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << pc_shift(PC_INC)) - 1);
    localparam logic [ADDR_W:0]   INC_EXT    = (ADDR_W + 1)'(PC_INC);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   pc_sum;
    logic              mem_rd;
    logic              fifo_push;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty, fifo_full;
    logic [INSTR_W+ADDR_W-1:0] fifo_rdata;

    // Extra top bit catches the carry out of the PC increment.
    assign pc_sum = {1'b0, fetch_pc_q} + INC_EXT;

    // Request issue, response handling and redirect (redirect overrides all).
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        err_d      = err_q;
        mem_rd     = 1'b0;
        fifo_push  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!halt && !redirect && (fifo_count < CNT_W'(DEPTH))) begin
                    mem_rd = 1'b1;
                    if (!bus.mem_stall) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_done) begin
                    state_d = ST_IDLE;
                    if (!redirect) begin
                        fifo_push  = !fifo_full;
                        fetch_pc_d = pc_sum[ADDR_W-1:0];
                        err_d      = err_q | pc_sum[ADDR_W];
                    end
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                // The stale response always retires the outstanding request,
                // even if another redirect lands on the same cycle.
                if (bus.mem_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            if ((redirect_pc & ALIGN_MASK) != '0) err_d = 1'b1;
        end
    end

    // State, PC and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            err_q      <= err_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W + ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (bus.instr_ready),
        .flush (redirect),
        .wdata ({bus.mem_data, fetch_pc_q}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus.mem_rd                 = mem_rd;
    assign bus.mem_addr               = fetch_pc_q;
    assign bus.instr_valid            = !fifo_empty;
    assign {bus.instr, bus.instr_pc}  = fifo_rdata;
    assign bus.instr_pc_inc           = bus.instr_pc + ADDR_W'(PC_INC);
    assign err                        = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, a queue-based reference model
// compared every cycle, and literal expectations at key points.
module tb_fetch_unit;

    localparam int AW     = 16;
    localparam int IW     = 16;
    localparam int DEPTH  = 2;
    localparam int PC_INC = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, halt, redirect, err;
    logic [15:0] redirect_pc;
    logic        halt2, err2, redirect2;
    logic [15:0] redirect_pc2;

    fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();
    fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus2 ();

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .PC_INC(PC_INC),
                 .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .halt(halt), .redirect(redirect),
        .redirect_pc(redirect_pc), .bus(bus), .err(err));

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .PC_INC(PC_INC),
                 .RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst(rst), .halt(halt2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .bus(bus2), .err(err2));

    int nchk = 0;
    int nfail = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- memory responder for dut (latency mem_lat) -----------
    int          mem_lat = 1;
    int          n_acc = 0;
    bit          m_acc, m_fin, pend;
    int          cd;
    logic [15:0] m_acc_addr, pend_addr;

    always @(negedge clk) begin
        m_acc      = bus.mem_rd && !bus.mem_stall;
        m_fin      = bus.mem_done;
        m_acc_addr = bus.mem_addr;
    end

    always @(posedge clk) begin
        #1;
        if (m_fin) pend = 0;
        if (m_acc) begin
            pend = 1; cd = mem_lat; pend_addr = m_acc_addr; n_acc++;
        end else if (pend) begin
            cd--;
        end
        bus.mem_done = pend && (cd == 1);
        if (pend && cd == 1) bus.mem_data = 16'h1234 + pend_addr;
    end

    // ---------------- 1-cycle responder for dut2 ---------------------------
    bit          acc2;
    logic [15:0] a2;
    always @(negedge clk) begin
        acc2 = bus2.mem_rd && !bus2.mem_stall;
        a2   = bus2.mem_addr;
    end
    always @(posedge clk) begin
        #1;
        bus2.mem_done = acc2;
        bus2.mem_data = ~a2;
    end

    // ---------------- reference model -------------------------------------
    typedef struct packed { logic [15:0] ins; logic [15:0] pc; } ent_t;
    ent_t        q[$];
    logic [15:0] m_pc;
    bit          m_busy, m_drop, m_err;

    always @(posedge clk) begin : mdl
        bit issue;
        int s;
        if (rst) begin
            q.delete(); m_pc = 16'h0000; m_busy = 0; m_drop = 0; m_err = 0;
        end else begin
            issue = !m_busy && !halt && !redirect && (q.size() < DEPTH);
            if (redirect) begin
                q.delete();
                if (m_busy && bus.mem_done) begin m_busy = 0; m_drop = 0; end
                else if (m_busy) m_drop = 1;
                m_pc = redirect_pc;
                if ((int'(redirect_pc) % PC_INC) != 0) m_err = 1;
            end else begin
                if (q.size() > 0 && bus.instr_ready) void'(q.pop_front());
                if (m_busy && bus.mem_done) begin
                    if (!m_drop) begin
                        q.push_back('{bus.mem_data, m_pc});
                        s = int'(m_pc) + PC_INC;
                        if (s >= 65536) m_err = 1;
                        m_pc = 16'(s);
                    end
                    m_busy = 0; m_drop = 0;
                end else if (issue && !bus.mem_stall) begin
                    m_busy = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin : cmp
        bit exp_rd;
        if (chk_en && !rst) begin
            exp_rd = !m_busy && !halt && !redirect && (q.size() < DEPTH);
            check("mem_rd", 32'(bus.mem_rd), 32'(exp_rd));
            if (exp_rd) check("mem_addr", 32'(bus.mem_addr), 32'(m_pc));
            check("instr_valid", 32'(bus.instr_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check("instr", 32'(bus.instr), 32'(q[0].ins));
                check("instr_pc", 32'(bus.instr_pc), 32'(q[0].pc));
                check("instr_pc_inc", 32'(bus.instr_pc_inc), 32'(16'(q[0].pc + 16'(PC_INC))));
            end
            check("err", 32'(err), 32'(m_err));
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_issue(output logic [15:0] a);
        int n = 0;
        @(negedge clk);
        while (!bus.mem_rd && n < 20) begin
            tick(); @(negedge clk); n++;
        end
        check("issue_seen", 32'(bus.mem_rd), 32'd1);
        a = bus.mem_addr;
    endtask

    task automatic do_reset();
        halt = 1; halt2 = 1; redirect = 0;
        rst = 1; tick(); tick();
        rst = 0; tick(); tick(); tick();
        chk_en = 1;
        @(negedge clk);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'h0000);
        check("rst_err2", 32'(err2), 32'd0);
        tick();
    endtask

    logic [15:0] a;
    int base;

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; halt = 1; halt2 = 1; redirect = 0; redirect_pc = 16'h0;
        redirect2 = 0; redirect_pc2 = 16'h0;
        bus.instr_ready = 1; bus.mem_stall = 0; bus.mem_done = 0; bus.mem_data = '0;
        bus2.instr_ready = 1; bus2.mem_stall = 0; bus2.mem_done = 0; bus2.mem_data = '0;

        // 1: streaming with 1-cycle memory
        do_reset();
        mem_lat = 1; bus.instr_ready = 1; halt = 0;
        wait_issue(a); check("t1_addr0", 32'(a), 32'h0000);
        tick(); tick();
        wait_issue(a); check("t1_addr2", 32'(a), 32'h0002);
        check("t1_instr", 32'(bus.instr), 32'h1234);
        check("t1_pc", 32'(bus.instr_pc), 32'h0000);
        check("t1_pcinc", 32'(bus.instr_pc_inc), 32'h0002);
        check("t1_err", 32'(err), 32'd0);
        tick();
        wait_issue(a); check("t1_addr4", 32'(a), 32'h0004);
        halt = 1; repeat (4) tick();

        // 2: decode back-pressure fills the FIFO
        do_reset();
        bus.instr_ready = 0; halt = 0; base = n_acc;
        wait_issue(a); check("t2_addr0", 32'(a), 32'h0000);
        tick(); tick();
        wait_issue(a); check("t2_addr2", 32'(a), 32'h0002);
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check("t2_no_rd", 32'(bus.mem_rd), 32'd0); tick();
        end
        check("t2_nreq", 32'(n_acc - base), 32'd2);
        bus.instr_ready = 1;
        @(negedge clk); check("t2_head0", 32'(bus.instr_pc), 32'h0000);
        tick();
        @(negedge clk);
        check("t2_rd4", 32'(bus.mem_rd), 32'd1);
        check("t2_addr4", 32'(bus.mem_addr), 32'h0004);
        check("t2_head2", 32'(bus.instr_pc), 32'h0002);
        halt = 1; tick(); repeat (4) tick();

        // 3a: redirect while waiting on 0x0004 (3-cycle memory)
        do_reset();
        mem_lat = 3; bus.instr_ready = 1; halt = 0;
        wait_issue(a); check("t3_addr0", 32'(a), 32'h0000);
        tick();
        wait_issue(a); check("t3_addr2", 32'(a), 32'h0002);
        tick(); bus.instr_ready = 0;
        wait_issue(a); check("t3_addr4", 32'(a), 32'h0004);
        tick(); redirect = 1; redirect_pc = 16'h0100;
        @(negedge clk); check("t3_valid_pre", 32'(bus.instr_valid), 32'd1);
        tick(); redirect = 0;
        @(negedge clk); check("t3_flushed", 32'(bus.instr_valid), 32'd0);
        wait_issue(a); check("t3_addr100", 32'(a), 32'h0100);
        check("t3_nopush", 32'(bus.instr_valid), 32'd0);
        halt = 1; bus.instr_ready = 1; tick(); repeat (5) tick();

        // 3b: redirect coincident with mem_done
        do_reset();
        mem_lat = 3; bus.instr_ready = 1; halt = 0;
        wait_issue(a); tick();
        wait_issue(a); tick(); bus.instr_ready = 0;
        wait_issue(a); check("t3b_addr4", 32'(a), 32'h0004);
        tick(); tick(); tick();
        redirect = 1; redirect_pc = 16'h0100;
        @(negedge clk); check("t3b_done_now", 32'(bus.mem_done), 32'd1);
        tick(); redirect = 0;
        wait_issue(a); check("t3b_addr100", 32'(a), 32'h0100);
        check("t3b_nopush", 32'(bus.instr_valid), 32'd0);
        halt = 1; bus.instr_ready = 1; tick(); repeat (5) tick();

        // 4: memory stall for 4 cycles
        do_reset();
        mem_lat = 1; bus.mem_stall = 1; halt = 0; base = n_acc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_rd", 32'(bus.mem_rd), 32'd1);
            check("t4_addr", 32'(bus.mem_addr), 32'h0000);
            tick();
        end
        check("t4_none_acc", 32'(n_acc - base), 32'd0);
        bus.mem_stall = 0;
        @(negedge clk); check("t4_rd_last", 32'(bus.mem_rd), 32'd1);
        tick();
        @(negedge clk); check("t4_accepted", 32'(bus.mem_rd), 32'd0);
        check("t4_nacc", 32'(n_acc - base), 32'd1);
        halt = 1; tick(); repeat (3) tick();

        // 5: halt during WAIT
        do_reset();
        mem_lat = 3; bus.instr_ready = 0; halt = 0;
        wait_issue(a); check("t5_addr0", 32'(a), 32'h0000);
        tick(); halt = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_no_rd", 32'(bus.mem_rd), 32'd0);
            if (i == 3) check("t5_buffered", 32'(bus.instr_valid), 32'd1);
            tick();
        end
        halt = 0;
        @(negedge clk);
        check("t5_resume", 32'(bus.mem_rd), 32'd1);
        check("t5_addr2", 32'(bus.mem_addr), 32'h0002);
        tick(); halt = 1; bus.instr_ready = 1; repeat (6) tick();

        // 6: misaligned redirect sets err, fetch continues at target
        do_reset();
        mem_lat = 1; bus.instr_ready = 1;
        redirect = 1; redirect_pc = 16'h0101;
        tick(); redirect = 0; halt = 0;
        @(negedge clk);
        check("t6_err", 32'(err), 32'd1);
        check("t6_addr", 32'(bus.mem_addr), 32'h0101);
        check("t6_rd", 32'(bus.mem_rd), 32'd1);
        tick(); tick(); tick(); halt = 1; tick(); tick(); tick();
        @(negedge clk); check("t6_sticky", 32'(err), 32'd1);
        tick();

        // 7: mem_done arriving after reset is ignored
        do_reset();
        mem_lat = 3; halt = 0;
        wait_issue(a); tick(); halt = 1;
        rst = 1; tick(); rst = 0; tick(); tick(); tick();
        @(negedge clk); check("t7_ignored", 32'(bus.instr_valid), 32'd0);
        tick(); halt = 0;
        wait_issue(a); check("t7_addr0", 32'(a), 32'h0000);
        tick(); halt = 1; repeat (5) tick();

        // 8: PC wrap from 0xFFFE on the second instance
        do_reset();
        halt2 = 0;
        @(negedge clk);
        check("t8_rd", 32'(bus2.mem_rd), 32'd1);
        check("t8_addr", 32'(bus2.mem_addr), 32'hFFFE);
        check("t8_err0", 32'(err2), 32'd0);
        tick(); tick();
        @(negedge clk);
        check("t8_err1", 32'(err2), 32'd1);
        check("t8_pc", 32'(bus2.instr_pc), 32'hFFFE);
        check("t8_pcinc", 32'(bus2.instr_pc_inc), 32'h0000);
        check("t8_instr", 32'(bus2.instr), 32'h0001);
        check("t8_next", 32'(bus2.mem_addr), 32'h0000);
        halt2 = 1; tick(); repeat (4) tick();
        @(negedge clk); check("t8_sticky", 32'(err2), 32'd1);
        tick();
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
